updown_modcounter: RTL and testbench

Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable and a terminal-count wrap pulse. It is the general-purpose counting primitive for timers, address generators and event counters, and replaces fixed 3-bit wrap-only counters. An optional saturate mode, selected at compile time, holds the count at its limits instead of wrapping.

---
 rtl/updown_modcounter.sv | 93 +++++++++
 tb/tb_updown_modcounter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/updown_modcounter.sv
// Up/down counter with programmable modulus (MAX_VAL+1), parallel load and wrap pulse.
// Optional compile-time saturate mode: define UDCNT_SAT_EN to add the sat port.
module updown_modcounter #(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RST_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UDCNT_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_modcounter: WIDTH=%0d outside 1..32", WIDTH);
  end
  if (MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("updown_modcounter: MAX_VAL=%0d outside 1..2**WIDTH-1", MAX_VAL);
  end
  if (RST_VAL > MAX_VAL) begin : g_bad_rst
    $error("updown_modcounter: RST_VAL=%0d exceeds MAX_VAL=%0d", RST_VAL, MAX_VAL);
  end

  logic             sat_mode;
  logic [WIDTH-1:0] nxt_cnt;
  logic             nxt_wrap;

`ifdef UDCNT_SAT_EN
  assign sat_mode = sat;
`else
  assign sat_mode = 1'b0;
`endif

  // Loads above the modulus clamp to MAX_VAL rather than dropping high bits.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return ({1'b0, v} > MAX_EXT) ? MAX_Q : v;
  endfunction

  // Returns {wrap, next_count} for an up step.
  function automatic logic [WIDTH:0] limit_up(input logic [WIDTH-1:0] c, input logic s);
    logic [WIDTH:0] sum;
    sum = {1'b0, c} + (WIDTH+1)'(1);
    if (sum > MAX_EXT)
      return s ? {1'b0, MAX_Q} : {1'b1, {WIDTH{1'b0}}};
    return {1'b0, sum[WIDTH-1:0]};
  endfunction

  // Returns {wrap, next_count} for a down step.
  function automatic logic [WIDTH:0] limit_down(input logic [WIDTH-1:0] c, input logic s);
    if (c == '0)
      return s ? {1'b0, {WIDTH{1'b0}}} : {1'b1, MAX_Q};
    return {1'b0, c - WIDTH'(1)};
  endfunction

  always_comb begin
    nxt_cnt  = out;
    nxt_wrap = 1'b0;
    if (load)
      nxt_cnt = clamp_load(load_val);
    else if (en && up_down)
      {nxt_wrap, nxt_cnt} = limit_up(out, sat_mode);
    else if (en)
      {nxt_wrap, nxt_cnt} = limit_down(out, sat_mode);
  end

  // Registered count and wrap pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out  <= RST_Q;
      wrap <= 1'b0;
    end else begin
      out  <= nxt_cnt;
      wrap <= nxt_wrap;
    end
  end

  assign at_max = (out == MAX_Q);
  assign at_min = (out == '0);

endmodule

// File: tb/tb_updown_modcounter.sv
// Bench for updown_modcounter (WIDTH=3, MAX_VAL=5): modulo reference model plus directed literals.
module tb_updown_modcounter;
  localparam int W   = 3;
  localparam int MAX = 5;

  logic         clk = 1'b0;
  logic         rstn;
  logic         en, up_down, load, sat;
  logic [W-1:0] load_val;
  logic [W-1:0] out;
  logic         wrap, at_max, at_min;

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  int m_wrap = 0;

  updown_modcounter #(.WIDTH(W), .MAX_VAL(MAX), .RST_VAL(0)) dut (
    .clk(clk), .rstn(rstn), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
`ifdef UDCNT_SAT_EN
    .sat(sat),
`endif
    .out(out), .wrap(wrap), .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: counting modulo MAX+1, with saturate holding at the limits.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt  <= 0;
      m_wrap <= 0;
    end else if (load) begin
      m_cnt  <= (int'(load_val) > MAX) ? MAX : int'(load_val);
      m_wrap <= 0;
    end else if (en && up_down) begin
      if (m_cnt == MAX && sat) begin
        m_cnt <= MAX; m_wrap <= 0;
      end else begin
        m_cnt <= (m_cnt + 1) % (MAX + 1); m_wrap <= (m_cnt == MAX) ? 1 : 0;
      end
    end else if (en) begin
      if (m_cnt == 0 && sat) begin
        m_cnt <= 0; m_wrap <= 0;
      end else begin
        m_cnt <= (m_cnt + MAX) % (MAX + 1); m_wrap <= (m_cnt == 0) ? 1 : 0;
      end
    end else begin
      m_wrap <= 0;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      check("model_out", int'(out), m_cnt);
      check("model_wrap", int'(wrap), m_wrap);
      check("model_at_max", int'(at_max), (m_cnt == MAX) ? 1 : 0);
      check("model_at_min", int'(at_min), (m_cnt == 0) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic step_expect(input string name, input int exp_out, input int exp_wrap);
    tick();
    check({name, "_out"}, int'(out), exp_out);
    check({name, "_wrap"}, int'(wrap), exp_wrap);
  endtask

  int up_out[8]  = '{1, 2, 3, 4, 5, 0, 1, 2};
  int up_wr[8]   = '{0, 0, 0, 0, 0, 1, 0, 0};
  int dn_out[4]  = '{1, 0, 5, 4};
  int dn_wr[4]   = '{0, 0, 1, 0};
  int wraps;

  initial begin
    rstn = 1'b0; en = 1'b0; up_down = 1'b1; load = 1'b0; load_val = '0; sat = 1'b0;
    #2;
    check("rst_out", int'(out), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_at_min", int'(at_min), 1);
    check("rst_at_max", int'(at_max), 0);
    #10;
    rstn = 1'b1; en = 1'b1; up_down = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step_expect("up_seq", up_out[i], up_wr[i]);
      check("up_at_max", int'(at_max), (up_out[i] == 5) ? 1 : 0);
    end

    up_down = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_expect("down_seq", dn_out[i], dn_wr[i]);
      check("down_at_min", int'(at_min), (dn_out[i] == 0) ? 1 : 0);
    end

    load = 1'b1; load_val = 3'd3; en = 1'b1; up_down = 1'b1;
    step_expect("load3", 3, 0);
    load_val = 3'd7;
    step_expect("load7_clamp", 5, 0);
    load_val = 3'd0;
    step_expect("load0_at_max", 0, 0);
    load_val = 3'd4;
    step_expect("load4", 4, 0);

    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_down = ~up_down;
      step_expect("hold", 4, 0);
    end

    #1;
    rstn = 1'b0;
    #1;
    check("async_rst_out", int'(out), 0);
    check("async_rst_wrap", int'(wrap), 0);
    #1;
    rstn = 1'b1; en = 1'b1; up_down = 1'b1;
    step_expect("resume", 1, 0);

    for (int i = 0; i < 4; i++) tick();
    check("pre_wrap_out", int'(out), 5);
    step_expect("wrap_before_rst", 0, 1);
    #1;
    rstn = 1'b0;
    #1;
    check("rst_clears_wrap", int'(wrap), 0);
    #1;
    rstn = 1'b1;

    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (wrap) wraps++;
    end
    check("wrap_period_count", wraps, 2);
    check("wrap_period_out", int'(out), 0);

`ifdef UDCNT_SAT_EN
    load = 1'b1; load_val = 3'd4;
    step_expect("sat_load4", 4, 0);
    load = 1'b0; sat = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 3; i++) step_expect("sat_up", 5, 0);
    up_down = 1'b0;
    for (int i = 4; i >= 0; i--) step_expect("sat_down", i, 0);
    for (int i = 0; i < 2; i++) step_expect("sat_hold0", 0, 0);
    sat = 1'b0;
    step_expect("sat_off_wrap", 5, 1);
`endif

    en = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
